// File: rtl/bsg_gateway_pkg.sv
// Shared types and widths for the gateway reset sequencer.
package bsg_gateway_pkg;

  // Width of the saturating restart counter.
  localparam int unsigned restart_cnt_width_lp = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_MB,
    REL_IO,
    REL_CORE,
    REL_MC,
    RUN
  } bsg_gateway_reset_state_e;

endpackage

// File: rtl/bsg_gateway_async_sync.sv
// Multi-stage flop chain that brings asynchronous level signals into the clk_i domain.
module bsg_gateway_async_sync #(
  parameter int unsigned width_p  = 1,
  parameter int unsigned stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] stage_q [stages_p];

  // Shift the raw input through the chain; cleared asynchronously by board reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < stages_p; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int unsigned i = 1; i < stages_p; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[stages_p-1];

endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Ordered reset release for the gateway FPGA domains (mb -> io -> core -> mc), gated on a
// stable PLL lock. Any lock loss or software restart re-asserts every reset at once.
module bsg_gateway_reset_seq
  import bsg_gateway_pkg::*;
#(
  parameter int unsigned sync_stages_p        = 2,
  parameter int unsigned lock_stable_cycles_p = 1024,
  parameter int unsigned gap_cycles_p         = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            pll_locked_i,
  input  logic                            sw_reset_i,
  output logic                            mb_reset_o,
  output logic                            io_reset_o,
  output logic                            core_reset_o,
  output logic                            mc_reset_o,
  output logic                            done_o,
  output logic [restart_cnt_width_lp-1:0] restart_cnt_o
);

  localparam int unsigned cnt_max_lp   = (lock_stable_cycles_p > gap_cycles_p) ?
                                         lock_stable_cycles_p : gap_cycles_p;
  localparam int unsigned cnt_width_lp = $clog2(cnt_max_lp + 1);

  localparam logic [cnt_width_lp-1:0] stable_last_lp = cnt_width_lp'(lock_stable_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] gap_last_lp    = cnt_width_lp'(gap_cycles_p - 1);

  bsg_gateway_reset_state_e state_q, state_d;
  logic [cnt_width_lp-1:0]         cnt_q, cnt_d;
  logic [restart_cnt_width_lp-1:0] restart_cnt_q, restart_cnt_d;
  logic mb_reset_q, mb_reset_d;
  logic io_reset_q, io_reset_d;
  logic core_reset_q, core_reset_d;
  logic mc_reset_q, mc_reset_d;
  logic done_q, done_d;

  logic [1:0] sync_out;
  logic       lock_s;
  logic       sw_s;
  logic       abort;

  bsg_gateway_async_sync #(
    .width_p  (2),
    .stages_p (sync_stages_p)
  ) u_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    ({pll_locked_i, sw_reset_i}),
    .data_o    (sync_out)
  );

  assign lock_s = sync_out[1];
  assign sw_s   = sync_out[0];

  // State, counters and registered outputs; reset holds every domain in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      restart_cnt_q <= '0;
      mb_reset_q    <= 1'b1;
      io_reset_q    <= 1'b1;
      core_reset_q  <= 1'b1;
      mc_reset_q    <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      restart_cnt_q <= restart_cnt_d;
      mb_reset_q    <= mb_reset_d;
      io_reset_q    <= io_reset_d;
      core_reset_q  <= core_reset_d;
      mc_reset_q    <= mc_reset_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic; abort takes priority over any terminal-count transition.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    restart_cnt_d = restart_cnt_q;
    abort         = (state_q != WAIT_LOCK) && (!lock_s || sw_s);

    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      // Only count restarts that undo at least one release.
      if ((state_q inside {REL_MB, REL_IO, REL_CORE, REL_MC, RUN}) && (restart_cnt_q != '1)) begin
        restart_cnt_d = restart_cnt_q + restart_cnt_width_lp'(1);
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          if (lock_s && !sw_s) state_d = STABLE;
        end
        STABLE: begin
          if (cnt_q == stable_last_lp) begin
            cnt_d   = '0;
            state_d = REL_MB;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
        REL_MB, REL_IO, REL_CORE: begin
          if (cnt_q == gap_last_lp) begin
            cnt_d   = '0;
            state_d = (state_q == REL_MB) ? REL_IO :
                      (state_q == REL_IO) ? REL_CORE : REL_MC;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
        REL_MC: begin
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  // Output decode from the next state so each reset flop changes on the transition edge.
  always_comb begin
    mb_reset_d   = state_d inside {WAIT_LOCK, STABLE};
    io_reset_d   = state_d inside {WAIT_LOCK, STABLE, REL_MB};
    core_reset_d = state_d inside {WAIT_LOCK, STABLE, REL_MB, REL_IO};
    mc_reset_d   = state_d inside {WAIT_LOCK, STABLE, REL_MB, REL_IO, REL_CORE};
    done_d       = (state_d == RUN);
  end

  assign mb_reset_o    = mb_reset_q;
  assign io_reset_o    = io_reset_q;
  assign core_reset_o  = core_reset_q;
  assign mc_reset_o    = mc_reset_q;
  assign done_o        = done_q;
  assign restart_cnt_o = restart_cnt_q;

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Directed bench for bsg_gateway_reset_seq with sync=2, stable=8, gap=4.
module tb_bsg_gateway_reset_seq;

  localparam int unsigned S = 2;
  localparam int unsigned L = 8;
  localparam int unsigned G = 4;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       pll_locked_i;
  logic       sw_reset_i;
  logic       mb_reset_o;
  logic       io_reset_o;
  logic       core_reset_o;
  logic       mc_reset_o;
  logic       done_o;
  logic [7:0] restart_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_gateway_reset_seq #(
    .sync_stages_p        (S),
    .lock_stable_cycles_p (L),
    .gap_cycles_p         (G)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .pll_locked_i  (pll_locked_i),
    .sw_reset_i    (sw_reset_i),
    .mb_reset_o    (mb_reset_o),
    .io_reset_o    (io_reset_o),
    .core_reset_o  (core_reset_o),
    .mc_reset_o    (mc_reset_o),
    .done_o        (done_o),
    .restart_cnt_o (restart_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_all_reset(input string tag, input logic [7:0] exp_cnt);
    chk({tag, "_mb"}, mb_reset_o, 1);
    chk({tag, "_io"}, io_reset_o, 1);
    chk({tag, "_core"}, core_reset_o, 1);
    chk({tag, "_mc"}, mc_reset_o, 1);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cnt"}, restart_cnt_o, exp_cnt);
  endtask

  // mb release expected exactly 'first' edges from now, then gap spacing, then done.
  task automatic check_release_seq(input int first, input logic [7:0] exp_cnt);
    ticks(first - 1);
    chk("mb_hold", mb_reset_o, 1);
    tick();
    chk("mb_rel", mb_reset_o, 0);
    chk("io_hold_at_mb", io_reset_o, 1);
    ticks(G - 1);
    chk("io_hold", io_reset_o, 1);
    tick();
    chk("io_rel", io_reset_o, 0);
    chk("core_hold_at_io", core_reset_o, 1);
    chk("mb_stays_rel", mb_reset_o, 0);
    ticks(G - 1);
    chk("core_hold", core_reset_o, 1);
    tick();
    chk("core_rel", core_reset_o, 0);
    chk("mc_hold_at_core", mc_reset_o, 1);
    ticks(G - 1);
    chk("mc_hold", mc_reset_o, 1);
    chk("done_pre", done_o, 0);
    tick();
    chk("mc_rel", mc_reset_o, 0);
    chk("done_at_mc", done_o, 0);
    tick();
    chk("done_rise", done_o, 1);
    chk("seq_cnt", restart_cnt_o, exp_cnt);
  endtask

  initial begin
    reset_n_i    = 1'b0;
    pll_locked_i = 1'b0;
    sw_reset_i   = 1'b0;

    // Power-on: reset low 5 cycles, lock rises at cycle 10.
    ticks(5);
    chk_all_reset("por", 8'd0);
    reset_n_i = 1'b1;
    ticks(5);
    pll_locked_i = 1'b1;
    check_release_seq(S + L + 1, 8'd0);

    // Re-enter reset, then a short lock pulse before any release.
    reset_n_i    = 1'b0;
    pll_locked_i = 1'b0;
    tick();
    chk_all_reset("rst2", 8'd0);
    tick();
    reset_n_i = 1'b1;
    ticks(3);
    pll_locked_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("glitch_hi_mb", mb_reset_o, 1);
    end
    pll_locked_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_lo_mb", mb_reset_o, 1);
    end
    chk("glitch_cnt", restart_cnt_o, 0);
    pll_locked_i = 1'b1;
    check_release_seq(S + L + 1, 8'd0);

    // One-cycle lock drop from RUN.
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    tick();
    chk("drop_e2_done", done_o, 1);
    chk("drop_e2_mb", mb_reset_o, 0);
    tick();
    chk_all_reset("drop_e3", 8'd1);
    check_release_seq(L + 1, 8'd1);

    // Software restart while in REL_IO.
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    ticks(2);
    chk("drop2_cnt", restart_cnt_o, 2);
    ticks(14);
    chk("in_relio_io", io_reset_o, 0);
    chk("in_relio_core", core_reset_o, 1);
    sw_reset_i = 1'b1;
    ticks(2);
    chk("sw_e2_io", io_reset_o, 0);
    chk("sw_e2_core", core_reset_o, 1);
    tick();
    chk_all_reset("sw_e3", 8'd3);
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("sw_hold_mb", mb_reset_o, 1);
      chk("sw_hold_mc", mc_reset_o, 1);
    end
    sw_reset_i = 1'b0;
    check_release_seq(S + L + 1, 8'd3);

    // Repeated aborts from RUN: counter must saturate, not wrap.
    for (int i = 0; i < 300; i++) begin
      pll_locked_i = 1'b0;
      tick();
      pll_locked_i = 1'b1;
      ticks(24);
      chk("sat_done", done_o, 1);
      chk("sat_cnt", restart_cnt_o, (3 + i + 1 > 255) ? 255 : 3 + i + 1);
    end

    // Asynchronous reset while in REL_CORE.
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    ticks(20);
    chk("relcore_core", core_reset_o, 0);
    chk("relcore_mc", mc_reset_o, 1);
    chk("relcore_cnt", restart_cnt_o, 255);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_all_reset("async_rst", 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
